// File: rtl/key_word_loader.sv
// key_word_loader: collects NWORDS x WORD_W key words in a shadow buffer and commits
// them atomically to key. Optional trailing XOR checksum word: `define KEY_CHECKSUM_EN.

module key_word_lane #(
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr,
  input  logic              discard,
  input  logic              commit,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] shadow,
  output logic [WORD_W-1:0] key
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shadow <= '0;
      key    <= '0;
    end else begin
      if (discard)  shadow <= '0;
      else if (wr)  shadow <= d;
      // the final word can land in the same edge as the commit, so bypass the shadow
      if (commit)   key <= wr ? d : shadow;
    end
  end
endmodule

module key_word_loader #(
  parameter int WORD_W = 64,
  parameter int NWORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WORD_W-1:0]        s_data,
  input  logic                     s_last,
  input  logic                     clear,
  output logic [WORD_W*NWORDS-1:0] key,
  output logic                     key_valid,
  input  logic                     key_ack,
  output logic                     key_err
);
`ifdef KEY_CHECKSUM_EN
  localparam int LAST_IDX = NWORDS;
`else
  localparam int LAST_IDX = NWORDS - 1;
`endif
  localparam int CNT_W = $clog2(NWORDS + 1);

  typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} state_t;
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              last;
  } word_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt;
  word_t                          in_word;
  logic                           accept, at_final, frame_err, ck_err, err, commit;
  logic [NWORDS-1:0][WORD_W-1:0]  shadow, key_q;
  logic [NWORDS-1:0]              lane_wr;

  assign in_word   = '{data: s_data, last: s_last};
  assign accept    = s_valid && s_ready && !clear;
  assign at_final  = (cnt == CNT_W'(LAST_IDX));
  assign frame_err = accept && (in_word.last != at_final);

`ifdef KEY_CHECKSUM_EN
  logic [WORD_W-1:0] ck_sum;
  always_comb begin
    ck_sum = '0;
    for (int i = 0; i < NWORDS; i++) ck_sum ^= shadow[i];
  end
  assign ck_err = accept && at_final && in_word.last && (in_word.data != ck_sum);
`else
  assign ck_err = 1'b0;
`endif

  assign err    = frame_err || ck_err;
  assign commit = accept && at_final && in_word.last && !ck_err;

  always_comb begin
    lane_wr = '0;
    for (int i = 0; i < NWORDS; i++)
      lane_wr[i] = accept && !err && (cnt == CNT_W'(i));
  end

  for (genvar i = 0; i < NWORDS; i++) begin : g_lane
    key_word_lane #(.WORD_W(WORD_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .wr      (lane_wr[i]),
      .discard (err),
      .commit  (commit),
      .d       (in_word.data),
      .shadow  (shadow[i]),
      .key     (key_q[i])
    );
  end

  assign key = key_q;

  always_ff @(posedge clk) begin
    if (rst || clear)  cnt <= '0;
    else if (accept)   cnt <= (err || commit) ? '0 : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) key_err <= 1'b0;
    else              key_err <= err;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) state_d = LOAD;
    else begin
      case (state_q)
        LOAD:    if (commit)  state_d = HOLD;
        HOLD:    if (key_ack) state_d = LOAD;
        default: state_d = LOAD;
      endcase
    end
  end

  always_comb begin
    s_ready   = (state_q == LOAD);
    key_valid = (state_q == HOLD);
  end
endmodule
